// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array blocks: drain FSM encoding and the
// ReLU/saturation helper used when narrowing accumulator results.
package systolic_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } drain_state_t;

    localparam int SYS_CALC_W = 64;

    // Optional ReLU, then clamp to the signed range of an out_w-bit value.
    function automatic logic signed [SYS_CALC_W-1:0] sat_relu(
        input logic signed [SYS_CALC_W-1:0] v,
        input logic                         relu_en,
        input int                           out_w
    );
        logic signed [SYS_CALC_W-1:0] hi;
        logic signed [SYS_CALC_W-1:0] lo;
        logic signed [SYS_CALC_W-1:0] r;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        r  = v;
        if (relu_en && (r < 64'sd0)) begin
            r = 64'sd0;
        end
        if (r > hi) begin
            r = hi;
        end else if (r < lo) begin
            r = lo;
        end
        return r;
    endfunction

endpackage

// File: rtl/sat_requant.sv
// Requantizes one signed accumulator: arithmetic shift, optional ReLU, saturate.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module sat_requant
    import systolic_pkg::*;
#(
    parameter int ACC_W = 32,
    parameter int OUT_W = 8
) (
    input  logic signed [ACC_W-1:0] acc,
    input  logic        [4:0]       shift,
    input  logic                    relu_en,
    output logic signed [OUT_W-1:0] q
);

    logic signed [ACC_W-1:0]      shifted;
    logic signed [SYS_CALC_W-1:0] wide;
    logic signed [SYS_CALC_W-1:0] sat;

    always_comb begin
        shifted = acc >>> shift;
        wide    = SYS_CALC_W'(shifted);
        sat     = sat_relu(wide, relu_en, OUT_W);
        q       = sat[OUT_W-1:0];
    end

endmodule

// File: rtl/systolic_result_drain.sv
// Captures a completed result tile and streams it out row-major, requantized.
// Latency: first element valid the cycle after done_in; back-to-back frames are gapless.
// Backpressure: valid/ready; element, last flag and index hold while m_ready is low.
module systolic_result_drain
    import systolic_pkg::*;
#(
    parameter int ACC_W = 32,
    parameter int ROWS  = 4,
    parameter int COLS  = 4,
    parameter int OUT_W = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        done_in,
    input  logic [ROWS*COLS*ACC_W-1:0]  c_flat,
    input  logic [4:0]                  shift,
    input  logic                        relu_en,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [OUT_W-1:0]            m_data,
    output logic                        m_last,
    output logic                        busy,
    output logic                        overrun,
    input  logic                        clear_err
);

    localparam int N     = ROWS * COLS;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    drain_state_t            state;
    logic [IDX_W-1:0]        idx;
    logic [N*ACC_W-1:0]      cbuf;
    logic [4:0]              shift_q;
    logic                    relu_q;

    logic signed [ACC_W-1:0] elem;
    logic signed [OUT_W-1:0] q;
    logic                    at_last;
    logic                    xfer;
    logic                    last_xfer;
    logic                    ovr_set;

    assign elem      = cbuf[idx*ACC_W +: ACC_W];
    assign at_last   = (idx == LAST_IDX);
    assign xfer      = m_valid && m_ready;
    assign last_xfer = xfer && at_last;
    // A new frame is only legal while idle or exactly on the final handshake.
    assign ovr_set   = (state == DRAIN) && done_in && !last_xfer;

    sat_requant #(
        .ACC_W (ACC_W),
        .OUT_W (OUT_W)
    ) u_requant (
        .acc     (elem),
        .shift   (shift_q),
        .relu_en (relu_q),
        .q       (q)
    );

    assign m_valid = (state == DRAIN);
    assign busy    = (state == DRAIN);
    assign m_last  = m_valid && at_last;
    assign m_data  = m_valid ? q : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            idx     <= '0;
            cbuf    <= '0;
            shift_q <= '0;
            relu_q  <= 1'b0;
            overrun <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (done_in) begin
                        cbuf    <= c_flat;
                        shift_q <= shift;
                        relu_q  <= relu_en;
                        idx     <= '0;
                        state   <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (xfer) begin
                        if (at_last) begin
                            idx <= '0;
                            if (done_in) begin
                                cbuf    <= c_flat;
                                shift_q <= shift;
                                relu_q  <= relu_en;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            if (ovr_set) begin
                overrun <= 1'b1;
            end else if (clear_err) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: doc/systolic_result_drain.md
SYSTOLIC_RESULT_DRAIN -- requirements
Module: systolic_result_drain

Interface
REQ-001 The block SHALL have parameter ACC_W, default 32, giving the width of each int32 result element on c_flat.
REQ-002 The block SHALL have parameter ROWS, default 4, giving the number of result rows.
REQ-003 The block SHALL have parameter COLS, default 4, giving the number of result columns.
REQ-004 The block SHALL have parameter OUT_W, default 8, giving the width of each output stream element.
REQ-005 clk input 1 -- clock; all logic SHALL be rising-edge triggered.
REQ-006 rst_n input 1 -- reset; asynchronous, active-low.
REQ-007 done_in input 1 -- one-cycle pulse from the array controller marking c_flat as complete.
REQ-008 c_flat input ROWS*COLS*ACC_W -- signed results; element i occupies bits [(i+1)*ACC_W-1 -: ACC_W], in row-major order.
REQ-009 shift input 5 -- arithmetic right-shift amount for requantization.
REQ-010 relu_en input 1 -- when 1, the block SHALL clamp negative results to 0.
REQ-011 m_valid output 1 -- the stream element is valid.
REQ-012 m_ready input 1 -- the downstream sink accepts the element.
REQ-013 m_data output OUT_W -- signed requantized element.
REQ-014 m_last output 1 -- set on element ROWS*COLS-1.
REQ-015 busy output 1 -- high while in the DRAIN state.
REQ-016 overrun output 1 -- sticky error flag.
REQ-017 clear_err input 1 -- synchronous clear of overrun.

Function
REQ-018 The FSM SHALL have exactly two states: IDLE and DRAIN.
REQ-019 In IDLE, done_in=1 SHALL capture c_flat, shift and relu_en into internal registers, set idx=0 and move to DRAIN on the next edge.
REQ-020 m_valid SHALL equal (state==DRAIN).
- Latency: done_in high in cycle N gives m_valid high in cycle N+1 with element 0 presented.
REQ-021 Requantization of element idx SHALL use the captured values only:
- step 1: v = c[idx] >>> shift (arithmetic shift, truncation toward -inf);
- step 2: if relu_en and v<0, then v=0;
- step 3: saturate v to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-022 A transfer SHALL occur when m_valid && m_ready, and SHALL advance idx by 1.
REQ-023 While m_valid && !m_ready, m_data and m_last SHALL stay stable and idx SHALL not change.
REQ-024 m_last SHALL equal m_valid && (idx==ROWS*COLS-1).
REQ-025 After the transfer of the last element, the block SHALL return to IDLE, so that m_valid is low in the following cycle.
REQ-026 If done_in coincides with the transfer of the last element, the block SHALL capture the new frame and stay in DRAIN with idx=0, giving a gapless back-to-back stream.
REQ-027 A done_in in DRAIN other than on the last transfer SHALL be ignored and SHALL set overrun=1; the frame being drained SHALL continue unchanged.
REQ-028 overrun SHALL stay set until a cycle with clear_err=1; if a set and clear_err occur in the same cycle, set SHALL win.
REQ-029 Changes on c_flat, shift or relu_en during DRAIN SHALL NOT affect output data.
REQ-030 A frame SHALL consist of exactly ROWS*COLS transfers; no element SHALL be skipped or duplicated.

Reset
REQ-031 rst_n=0 SHALL asynchronously force:
- state=IDLE, idx=0;
- m_valid=0, m_last=0, m_data=0;
- busy=0, overrun=0;
- captured buffer = 0.
REQ-032 Reset asserted mid-DRAIN SHALL abandon the frame; after release the block SHALL wait for a new done_in.

Structure
REQ-033 The FSM state encoding and the saturation/ReLU helper SHALL be defined in the shared systolic package (systolic_pkg), reused by the other systolic blocks.
REQ-034 Requantization SHALL be one combinational sub-module, sat_requant (parameters ACC_W and OUT_W), instantiated once on the selected element.
REQ-035 The block SHALL use a single buffer of ROWS*COLS*ACC_W bits; no FIFO.

Verification
REQ-036 Basic frame: 4x4 results c[i]=i*256, shift=8, relu_en=0, m_ready=1 -> 16 consecutive beats with data 0..15, m_last on beat 16, m_valid first high one cycle after done_in.
REQ-037 Saturation and ReLU: c={-100000, 100000, -5, 5}, remainder 0, shift=0:
- relu_en=0 -> -128, 127, -5, 5;
- relu_en=1 -> 0, 127, 0, 5.
REQ-038 Backpressure: m_ready low for 3 cycles at beat 5 -> m_data and m_last held constant, no element lost or duplicated.
REQ-039 Back-to-back frames: done_in asserted on the last-beat transfer -> m_valid never drops, second frame starts at element 0, overrun stays 0.
REQ-040 Overrun: done_in at beat 3 -> overrun=1, first frame completes intact; clear_err pulse -> overrun=0; clear_err coinciding with a new overrun -> overrun stays 1.
REQ-041 Reset mid-drain: rst_n low at beat 7 -> all outputs 0 immediately; after release, no output until the next done_in.
